// File: rtl/iterative_shift_right_if.sv
// Signal bundle between the multi-cycle control FSM (master) and the
// iterative right-shift unit (slave).
interface iterative_shift_right_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
);
    // Handshake: start is a request that is accepted on any rising edge where
    // the unit is not busy (IDLE or DONE) and reset is low; there is no
    // backpressure. done is a one-cycle pulse, and dataOut is valid from that
    // cycle until the next completion.
    logic               start;
    logic [WIDTH-1:0]   dataIn;
    logic [SHAMT_W-1:0] shamt;
    logic               arith;
    logic               busy;
    logic               done;
    logic [WIDTH-1:0]   dataOut;
    logic [1:0]         state_dbg;

    modport master (
        output start, dataIn, shamt, arith,
        input  busy, done, dataOut, state_dbg
    );

    modport slave (
        input  start, dataIn, shamt, arith,
        output busy, done, dataOut, state_dbg
    );
endinterface

// File: rtl/iterative_shift_right.sv
// Multi-cycle SRL/SRA unit: shifts the latched operand right by one bit per
// clock and presents the result with a one-cycle done pulse.
module iterative_shift_right #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    iterative_shift_right_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   work;
    logic [SHAMT_W-1:0] cnt;
    logic               arith_q;
    logic [WIDTH-1:0]   data_out;
    logic [WIDTH-1:0]   shifted;
    logic               accept;
    logic               last_shift;

    assign shifted    = {arith_q & work[WIDTH-1], work[WIDTH-1:1]};
    assign accept     = ((state == IDLE) || (state == DONE)) && bus.start;
    assign last_shift = (state == SHIFT) && (cnt == SHAMT_W'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_next = (bus.shamt == '0) ? DONE : SHIFT;
                end else begin
                    state_next = IDLE;
                end
            end
            SHIFT: begin
                if (cnt == SHAMT_W'(1)) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // dataOut only moves on the edge that enters DONE; it is held otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            work     <= '0;
            cnt      <= '0;
            arith_q  <= 1'b0;
            data_out <= '0;
        end else if (accept) begin
            work    <= bus.dataIn;
            cnt     <= bus.shamt;
            arith_q <= bus.arith;
            if (bus.shamt == '0) begin
                data_out <= bus.dataIn;
            end
        end else if (state == SHIFT) begin
            work <= shifted;
            cnt  <= cnt - SHAMT_W'(1);
            if (last_shift) begin
                data_out <= shifted;
            end
        end
    end

    assign bus.busy      = (state == SHIFT);
    assign bus.done      = (state == DONE);
    assign bus.dataOut   = data_out;
    assign bus.state_dbg = state;

endmodule
